div_unit: RTL and testbench

Iterative multi-cycle divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits between the register file read ports and its write port. It consumes the rs1/rs2 read data, stalls the single-cycle core while it computes, and drives a one-cycle writeback of the quotient or remainder to rd. It uses restoring division at one quotient bit per clock, with early completion for divide-by-zero and signed overflow.

---
 rtl/div_unit.sv | 142 ++++++++++++++
 tb/tb_div_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
`timescale 1ns/1ps
// div_unit: iterative RV32M divider (DIV/DIVU/REM/REMU).
// Restoring division, one quotient bit per clock. Divide-by-zero and
// signed overflow finish straight from IDLE without any CALC cycles.
// Handshake: start_i is a level held by the core for the whole
// instruction; the unit stalls the core (stall_o) until the single-cycle
// writeback strobe wb_en_o in DONE, and ignores start_i until back in IDLE.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] rs1_data_i,
   input  logic [WIDTH-1:0] rs2_data_i,
   input  logic [4:0]       rd_addr_i,
   output logic             stall_o,
   output logic             busy_o,
   output logic             wb_en_o,
   output logic [4:0]       wb_addr_o,
   output logic [WIDTH-1:0] wb_data_o,
   output logic [1:0]       dbg_state_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q;
   logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
   logic             q_neg_q, r_neg_q, sel_rem_q;
   logic [4:0]       rd_q;

   // Operand decode, only meaningful while IDLE with start_i high
   logic             is_signed, rs1_neg, rs2_neg;
   logic [WIDTH-1:0] rs1_abs, rs2_abs, special_res;
   logic             div_zero, overflow, special;

   assign is_signed = ~op_i[0];
   assign rs1_neg   = is_signed & rs1_data_i[WIDTH-1];
   assign rs2_neg   = is_signed & rs2_data_i[WIDTH-1];
   assign rs1_abs   = rs1_neg ? -rs1_data_i : rs1_data_i;
   assign rs2_abs   = rs2_neg ? -rs2_data_i : rs2_data_i;
   assign div_zero  = (rs2_data_i == '0);
   assign overflow  = is_signed & (rs1_data_i == MIN_NEG) & (rs2_data_i == '1);
   assign special   = div_zero | overflow;
   // Overflow quotient equals the dividend (most negative value)
   assign special_res = div_zero ? (op_i[1] ? rs1_data_i : '1)
                                 : (op_i[1] ? '0 : rs1_data_i);

   // Restoring step: shift {rem, quo} left, trial-subtract with explicit borrow
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH+1:0] diff;
   logic             borrow;
   logic [WIDTH-1:0] rem_nx, quo_nx, q_fix, r_fix, calc_res;
   logic             unused_bits;

   assign rem_sh   = {rem_q, quo_q[WIDTH-1]};
   assign diff     = {1'b0, rem_sh} - {2'b00, dvs_q};
   assign borrow   = diff[WIDTH+1];
   assign rem_nx   = borrow ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
   assign quo_nx   = {quo_q[WIDTH-2:0], ~borrow};
   assign q_fix    = q_neg_q ? -quo_nx : quo_nx;
   assign r_fix    = r_neg_q ? -rem_nx : rem_nx;
   assign calc_res = sel_rem_q ? r_fix : q_fix;
   // Top bits are provably zero once the trial subtraction is kept
   assign unused_bits = ^{diff[WIDTH], rem_sh[WIDTH]};

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i) state_d = special ? DONE : CALC;
         CALC:    if (count_q == LAST_CNT) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign stall_o     = rst_ni & (((state_q == IDLE) & start_i) | (state_q == CALC));
   assign busy_o      = (state_q == CALC);
   assign wb_en_o     = (state_q == DONE);
   assign dbg_state_o = state_q;

   // Operand capture, iteration datapath and writeback registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q   <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         q_neg_q   <= 1'b0;
         r_neg_q   <= 1'b0;
         sel_rem_q <= 1'b0;
         rd_q      <= '0;
         wb_addr_o <= '0;
         wb_data_o <= '0;
      end else begin
         case (state_q)
            IDLE: if (start_i) begin
               count_q   <= '0;
               rem_q     <= '0;
               quo_q     <= rs1_abs;
               dvs_q     <= rs2_abs;
               q_neg_q   <= rs1_neg ^ rs2_neg;
               r_neg_q   <= rs1_neg;
               sel_rem_q <= op_i[1];
               rd_q      <= rd_addr_i;
               if (special) begin
                  wb_data_o <= special_res;
                  wb_addr_o <= rd_addr_i;
               end
            end
            CALC: begin
               rem_q   <= rem_nx;
               quo_q   <= quo_nx;
               count_q <= count_q + CNT_W'(1);
               if (count_q == LAST_CNT) begin
                  wb_data_o <= calc_res;
                  wb_addr_o <= rd_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
`timescale 1ns/1ps
// Directed bench for div_unit: timing of stall/busy/writeback and results.
module tb_div_unit;
   localparam int W = 32;
   localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] rs1, rs2;
   logic [4:0]   rd;
   logic         stall, busy, wb_en;
   logic [4:0]   wb_addr;
   logic [W-1:0] wb_data;
   logic [1:0]   dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   div_unit #(.WIDTH(W)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op),
      .rs1_data_i(rs1), .rs2_data_i(rs2), .rd_addr_i(rd),
      .stall_o(stall), .busy_o(busy), .wb_en_o(wb_en),
      .wb_addr_o(wb_addr), .wb_data_o(wb_data), .dbg_state_o(dbg_state)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b1; op = OP_DIVU; rs1 = 32'd10; rs2 = 32'd2; rd = 5'd4;
      #2;
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_checks++; if (wb_en !== 1'b0) begin n_fail++; $display("FAIL reset_wb_en got %b want 0", wb_en); end
      n_checks++; if (wb_addr !== 5'd0) begin n_fail++; $display("FAIL reset_wb_addr got %0d want 0", wb_addr); end
      n_checks++; if (wb_data !== 32'd0) begin n_fail++; $display("FAIL reset_wb_data got %h want 0", wb_data); end
      n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", dbg_state); end
      tick(); tick();
      n_checks++; if (stall !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_hold stall=%b busy=%b want 0 0", stall, busy); end
      start = 1'b0;
      rst_n = 1'b1;
      tick();
   endtask

   // Normal op: start in cycle 0, CALC cycles 1..W, DONE at W+1, IDLE at W+2.
   // With tog set, operand inputs are scrambled during CALC and DONE.
   task automatic run_normal(input string name, input logic [1:0] o, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [4:0] r, input logic [W-1:0] exp,
                             input bit tog);
      int pulses = 0;
      start = 1'b1; op = o; rs1 = a; rs2 = b; rd = r;
      #1;
      for (int cyc = 0; cyc <= W + 1; cyc++) begin
         if (cyc > 0) tick();
         if (tog && cyc >= 2) begin
            op = OP_REMU; rs1 = 32'd5 + 32'(cyc); rs2 = (cyc % 2 == 0) ? 32'd0 : 32'd3; rd = 5'd1;
            #1;
         end
         if (wb_en === 1'b1) pulses++;
         n_checks++;
         if (stall !== (cyc <= W)) begin n_fail++; $display("FAIL %s stall cyc%0d got %b want %b", name, cyc, stall, cyc <= W); end
         n_checks++;
         if (busy !== (cyc >= 1 && cyc <= W)) begin n_fail++; $display("FAIL %s busy cyc%0d got %b", name, cyc, busy); end
         n_checks++;
         if (wb_en !== (cyc == W + 1)) begin n_fail++; $display("FAIL %s wb_en cyc%0d got %b", name, cyc, wb_en); end
         if (cyc == W + 1) begin
            n_checks++;
            if (wb_addr !== r) begin n_fail++; $display("FAIL %s wb_addr got %0d want %0d", name, wb_addr, r); end
            n_checks++;
            if (wb_data !== exp) begin n_fail++; $display("FAIL %s wb_data got %h want %h", name, wb_data, exp); end
         end
      end
      tick();
      start = 1'b0;
      #1;
      if (wb_en === 1'b1) pulses++;
      n_checks++;
      if (wb_en !== 1'b0 || busy !== 1'b0 || stall !== 1'b0) begin
         n_fail++; $display("FAIL %s idle_after wb_en=%b busy=%b stall=%b want 0 0 0", name, wb_en, busy, stall);
      end
      n_checks++;
      if (wb_data !== exp) begin n_fail++; $display("FAIL %s wb_data_hold got %h want %h", name, wb_data, exp); end
      n_checks++;
      if (pulses != 1) begin n_fail++; $display("FAIL %s wb_pulses got %0d want 1", name, pulses); end
   endtask

   // Special case: stall only in cycle 0, DONE at cycle 1.
   task automatic run_special(input string name, input logic [1:0] o, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [4:0] r, input logic [W-1:0] exp);
      start = 1'b1; op = o; rs1 = a; rs2 = b; rd = r;
      #1;
      n_checks++;
      if (stall !== 1'b1 || busy !== 1'b0 || wb_en !== 1'b0) begin
         n_fail++; $display("FAIL %s cyc0 stall=%b busy=%b wb_en=%b want 1 0 0", name, stall, busy, wb_en);
      end
      tick();
      n_checks++;
      if (wb_en !== 1'b1 || stall !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL %s cyc1 wb_en=%b stall=%b busy=%b want 1 0 0", name, wb_en, stall, busy);
      end
      n_checks++;
      if (wb_data !== exp) begin n_fail++; $display("FAIL %s wb_data got %h want %h", name, wb_data, exp); end
      n_checks++;
      if (wb_addr !== r) begin n_fail++; $display("FAIL %s wb_addr got %0d want %0d", name, wb_addr, r); end
      tick();
      start = 1'b0;
      #1;
      n_checks++;
      if (wb_en !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL %s cyc2 wb_en=%b stall=%b want 0 0", name, wb_en, stall); end
   endtask

   task automatic test_unsigned();
      run_normal("divu_100_7", OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 1'b0);
      run_normal("remu_100_7", OP_REMU, 32'd100, 32'd7, 5'd6, 32'd2, 1'b0);
   endtask

   task automatic test_signed();
      run_normal("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF, 1'b0);
      run_normal("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFD, 1'b0);
      run_normal("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd12, 32'hFFFF_FFFD, 1'b0);
      run_normal("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 5'd13, 32'd1, 1'b0);
   endtask

   task automatic test_div_zero();
      run_special("divu_by0", OP_DIVU, 32'd5, 32'd0, 5'd2, 32'hFFFF_FFFF);
      run_special("remu_by0", OP_REMU, 32'd5, 32'd0, 5'd3, 32'd5);
      run_special("div_by0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 5'd0, 32'hFFFF_FFFF);
      run_special("rem_by0", OP_REM, 32'hFFFF_FFFB, 32'd0, 5'd31, 32'hFFFF_FFFB);
   endtask

   task automatic test_overflow();
      run_special("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h8000_0000);
      run_special("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'd0);
      // Same operands unsigned are an ordinary divide
      run_normal("divu_min_max", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'd0, 1'b0);
   endtask

   task automatic test_boundary();
      run_normal("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd14, 32'hFFFF_FFFF, 1'b0);
      run_normal("remu_1_max", OP_REMU, 32'd1, 32'hFFFF_FFFF, 5'd15, 32'd1, 1'b0);
      run_normal("div_min_2", OP_DIV, 32'h8000_0000, 32'd2, 5'd16, 32'hC000_0000, 1'b0);
   endtask

   task automatic test_reset_mid();
      int pulses = 0;
      start = 1'b1; op = OP_DIVU; rs1 = 32'd1000; rs2 = 32'd3; rd = 5'd20;
      #1;
      for (int cyc = 1; cyc <= 10; cyc++) tick();
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid busy_before got %b want 1", busy); end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0 || stall !== 1'b0 || wb_en !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid async_drop busy=%b stall=%b wb_en=%b want 0 0 0", busy, stall, wb_en);
      end
      n_checks++;
      if (wb_data !== 32'd0 || wb_addr !== 5'd0) begin
         n_fail++; $display("FAIL rst_mid wb_regs data=%h addr=%0d want 0 0", wb_data, wb_addr);
      end
      tick(); tick();
      start = 1'b0;
      rst_n = 1'b1;
      for (int cyc = 0; cyc < 40; cyc++) begin
         tick();
         if (wb_en !== 1'b0) pulses++;
      end
      n_checks++;
      if (pulses != 0) begin n_fail++; $display("FAIL rst_mid stray_wb got %0d want 0", pulses); end
      run_normal("divu_9_3_after_rst", OP_DIVU, 32'd9, 32'd3, 5'd21, 32'd3, 1'b0);
   endtask

   task automatic test_operand_toggle();
      run_normal("div_toggle", OP_DIV, 32'hFFFF_FF9C, 32'd7, 5'd9, 32'hFFFF_FFF2, 1'b1);
   endtask

   task automatic test_back_to_back();
      // Each call issues its start in the IDLE cycle right after the previous DONE
      run_special("b2b_special", OP_DIVU, 32'd77, 32'd0, 5'd17, 32'hFFFF_FFFF);
      run_normal("b2b_first", OP_DIVU, 32'd1234567, 32'd1000, 5'd18, 32'd1234, 1'b0);
      run_normal("b2b_second", OP_REMU, 32'd1234567, 32'd1000, 5'd19, 32'd567, 1'b0);
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_div_zero();
      test_overflow();
      test_boundary();
      test_reset_mid();
      test_operand_toggle();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
